// File: rtl/usbh_tx_pump_pkg.sv
// Shared definitions for the USB host transmit path.
//   st_t           : transmit pump state encoding
//   CRC16_POLY_REF : reflected USB CRC16 polynomial
//   CRC16_INIT     : CRC16 preset value
//   PID_*          : PID byte constants (DATA0, DATA1, ACK)
package usbh_tx_pump_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_PID    = 3'd1,
    ST_DATA   = 3'd2,
    ST_CRC_LO = 3'd3,
    ST_CRC_HI = 3'd4
  } st_t;

  localparam logic [15:0] CRC16_POLY_REF = 16'hA001;
  localparam logic [15:0] CRC16_INIT     = 16'hFFFF;

  localparam logic [7:0] PID_DATA0 = 8'hC3;
  localparam logic [7:0] PID_DATA1 = 8'h4B;
  localparam logic [7:0] PID_ACK   = 8'hD2;

endpackage

// File: rtl/usbh_crc16.sv
// Combinational byte-wide USB CRC16 update (reflected, LSB first).
//   crc_in  : running CRC before this byte
//   data_in : byte to fold in
//   crc_out : running CRC after this byte
module usbh_crc16
  import usbh_tx_pump_pkg::*;
(
  input  logic [15:0] crc_in,
  input  logic [7:0]  data_in,
  output logic [15:0] crc_out
);

  logic [15:0] c;

  // XOR the whole byte in first, then shift eight times; equivalent to
  // feeding the bits LSB first one at a time.
  always_comb begin
    c = crc_in ^ {8'h00, data_in};
    for (int i = 0; i < 8; i++)
      c = c[0] ? ((c >> 1) ^ CRC16_POLY_REF) : (c >> 1);
    crc_out = c;
  end

endmodule

// File: rtl/usbh_tx_pump.sv
// USB full-speed host transmit pump: PID, payload from FWFT FIFO, CRC16.
//   clk_i/rst_i          : clock, synchronous active-high reset
//   start_i, pid_i,
//   len_i, pid_only_i    : packet request, sampled in IDLE only
//   fifo_data_i/empty_i  : FWFT FIFO head
//   fifo_pop_o           : pop head (combinational from txready/empty)
//   fifo_flush_o         : one-cycle flush on underrun abort
//   utmi_data_o/txvalid_o/txready_i : UTMI transmit handshake
//   busy_o, done_o, underrun_o : status
module usbh_tx_pump
  import usbh_tx_pump_pkg::*;
#(
  parameter int LEN_W = 11
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [7:0]       pid_i,
  input  logic [LEN_W-1:0] len_i,
  input  logic             pid_only_i,
  input  logic [7:0]       fifo_data_i,
  input  logic             fifo_empty_i,
  output logic             fifo_pop_o,
  output logic             fifo_flush_o,
  output logic [7:0]       utmi_data_o,
  output logic             utmi_txvalid_o,
  input  logic             utmi_txready_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             underrun_o
);

  st_t              state_q, state_d;
  logic [7:0]       pid_q;
  logic             pid_only_q;
  logic [LEN_W-1:0] cnt_q;
  logic [15:0]      crc_q, crc_next;
  logic             done_d, underrun_d, flush_d;

  usbh_crc16 u_crc (
    .crc_in  (crc_q),
    .data_in (fifo_data_i),
    .crc_out (crc_next)
  );

  assign busy_o = (state_q != ST_IDLE);

  always_comb begin
    state_d        = state_q;
    done_d         = 1'b0;
    underrun_d     = 1'b0;
    flush_d        = 1'b0;
    utmi_data_o    = 8'h00;
    utmi_txvalid_o = 1'b0;
    fifo_pop_o     = 1'b0;
    case (state_q)
      ST_IDLE: if (start_i) state_d = ST_PID;
      ST_PID: begin
        utmi_data_o    = pid_q;
        utmi_txvalid_o = 1'b1;
        if (utmi_txready_i) begin
          if (pid_only_q) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else if (cnt_q == '0) state_d = ST_CRC_LO;
          else                      state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        // Data path passes straight through; the FWFT head only moves on a
        // pop, so the byte stays stable under backpressure.
        utmi_data_o    = fifo_data_i;
        utmi_txvalid_o = !fifo_empty_i;
        if (fifo_empty_i) begin
          state_d    = ST_IDLE;
          done_d     = 1'b1;
          underrun_d = 1'b1;
          flush_d    = 1'b1;
        end else if (utmi_txready_i) begin
          fifo_pop_o = 1'b1;
          if (cnt_q == LEN_W'(1)) state_d = ST_CRC_LO;
        end
      end
      ST_CRC_LO: begin
        utmi_data_o    = ~crc_q[7:0];
        utmi_txvalid_o = 1'b1;
        if (utmi_txready_i) state_d = ST_CRC_HI;
      end
      ST_CRC_HI: begin
        utmi_data_o    = ~crc_q[15:8];
        utmi_txvalid_o = 1'b1;
        if (utmi_txready_i) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      pid_q        <= 8'h00;
      pid_only_q   <= 1'b0;
      cnt_q        <= '0;
      crc_q        <= CRC16_INIT;
      done_o       <= 1'b0;
      underrun_o   <= 1'b0;
      fifo_flush_o <= 1'b0;
    end else begin
      state_q      <= state_d;
      done_o       <= done_d;
      underrun_o   <= underrun_d;
      fifo_flush_o <= flush_d;
      if (state_q == ST_IDLE && start_i) begin
        pid_q      <= pid_i;
        pid_only_q <= pid_only_i;
        cnt_q      <= len_i;
        crc_q      <= CRC16_INIT;
      end else if (fifo_pop_o && cnt_q != '0) begin
        cnt_q <= cnt_q - LEN_W'(1);
        crc_q <= crc_next;
      end
    end
  end

endmodule

// File: tb/tb_usbh_tx_pump.sv
module tb_usbh_tx_pump;
  import usbh_tx_pump_pkg::*;

  localparam int LEN_W = 11;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [7:0]       pid = 8'h00;
  logic [LEN_W-1:0] len = '0;
  logic             pid_only = 1'b0;
  logic [7:0]       fifo_data = 8'h00;
  logic             fifo_empty = 1'b1;
  logic             txready = 1'b0;
  logic             fifo_pop, fifo_flush, txvalid, busy, done, underrun;
  logic [7:0]       utmi_data;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  usbh_tx_pump #(.LEN_W(LEN_W)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .pid_i(pid), .len_i(len),
    .pid_only_i(pid_only), .fifo_data_i(fifo_data), .fifo_empty_i(fifo_empty),
    .fifo_pop_o(fifo_pop), .fifo_flush_o(fifo_flush), .utmi_data_o(utmi_data),
    .utmi_txvalid_o(txvalid), .utmi_txready_i(txready), .busy_o(busy),
    .done_o(done), .underrun_o(underrun)
  );

  // FWFT FIFO model
  byte unsigned fq[$];
  int pops = 0;
  always @(posedge clk) begin
    if (fifo_flush) fq.delete();
    else if (fifo_pop && fq.size() > 0) begin
      void'(fq.pop_front());
      pops++;
    end
    fifo_empty <= (fq.size() == 0);
    fifo_data  <= (fq.size() > 0) ? fq[0] : 8'h00;
  end

  // Bit-serial reference CRC, transmitted (inverted) form
  function automatic logic [15:0] crc_tx(input byte unsigned d[$]);
    logic [15:0] c = 16'hFFFF;
    logic fb;
    foreach (d[k])
      for (int j = 0; j < 8; j++) begin
        fb = c[0] ^ d[k][j];
        c  = {1'b0, c[15:1]};
        if (fb) c = c ^ 16'hA001;
      end
    return ~c;
  endfunction

  // Packet driver: records accepted bytes and timing
  logic [7:0] got [0:15];
  int  ngot, first_v, last_acc, done_cyc, hold_err;
  bit  saw_under, saw_flush, timed_out;

  task automatic run_pkt(input logic [7:0] p, input logic [LEN_W-1:0] l,
                         input logic po, input int mode, input bit poke_busy);
    logic pv, pr;
    logic [7:0] pd;
    ngot = 0; first_v = -1; last_acc = -1; done_cyc = -1; hold_err = 0;
    saw_under = 0; saw_flush = 0; timed_out = 1; pv = 0; pr = 0; pd = 8'h00;
    @(negedge clk); pid = p; len = l; pid_only = po; start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int cyc = 0; cyc < 100; cyc++) begin
      if (cyc > 0) @(negedge clk);
      if (poke_busy && cyc == 1) begin
        start = 1'b1; pid = PID_DATA1; len = 11'd5; pid_only = 1'b0;
      end else start = 1'b0;
      case (mode)
        0:       txready = 1'b1;
        1:       txready = (cyc % 2 == 1);
        default: txready = (cyc >= 3);
      endcase
      #1;
      if (done) begin
        done_cyc = cyc; saw_under = underrun; saw_flush = fifo_flush;
        timed_out = 0;
        break;
      end
      if (txvalid) begin
        if (first_v < 0) first_v = cyc;
        if (pv && !pr && utmi_data !== pd) hold_err++;
      end
      if (txvalid && txready) begin
        if (ngot < 16) got[ngot] = utmi_data;
        ngot++;
        last_acc = cyc;
      end
      pv = txvalid; pr = txready; pd = utmi_data;
    end
    start = 1'b0;
    checks++;
    if (timed_out) begin
      failures++;
      $display("FAIL timeout pid=%h: no done_o within 100 cycles", p);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if ({txvalid, utmi_data, busy, done, underrun, fifo_flush, fifo_pop} !== 14'h0) begin
      failures++;
      $display("FAIL reset_outputs: valid=%b data=%h busy=%b done=%b und=%b flush=%b pop=%b expected all 0",
               txvalid, utmi_data, busy, done, underrun, fifo_flush, fifo_pop);
    end
    rst = 1'b0;
    @(negedge clk); #1;
    checks++;
    if (busy !== 1'b0) begin
      failures++; $display("FAIL idle_busy: got %b expected 0", busy);
    end
  endtask

  task automatic test_zero_len();
    logic [7:0] exp_b [3];
    exp_b = '{8'hC3, 8'h00, 8'h00};
    pops = 0;
    run_pkt(PID_DATA0, 11'd0, 1'b0, 0, 1'b0);
    checks++;
    if (ngot !== 3) begin failures++; $display("FAIL zl_count: got %0d expected 3", ngot); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (got[i] !== exp_b[i]) begin
        failures++; $display("FAIL zl_byte%0d: got %h expected %h", i, got[i], exp_b[i]);
      end
    end
    checks++;
    if (done_cyc !== last_acc + 1) begin
      failures++; $display("FAIL zl_done_timing: done at %0d expected %0d", done_cyc, last_acc + 1);
    end
    checks++;
    if (last_acc - first_v + 1 !== 3) begin
      failures++; $display("FAIL zl_span: got %0d expected 3", last_acc - first_v + 1);
    end
    checks++;
    if (pops !== 0) begin failures++; $display("FAIL zl_pops: got %0d expected 0", pops); end
  endtask

  task automatic test_one_byte();
    logic [7:0] exp_b [4];
    exp_b = '{8'hC3, 8'h00, 8'h40, 8'hBF};
    pops = 0;
    fq.push_back(8'h00);
    run_pkt(PID_DATA0, 11'd1, 1'b0, 0, 1'b0);
    checks++;
    if (ngot !== 4) begin failures++; $display("FAIL one_count: got %0d expected 4", ngot); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (got[i] !== exp_b[i]) begin
        failures++; $display("FAIL one_byte%0d: got %h expected %h", i, got[i], exp_b[i]);
      end
    end
    checks++;
    if (pops !== 1) begin failures++; $display("FAIL one_pops: got %0d expected 1", pops); end
    checks++;
    if (last_acc - first_v + 1 !== 4) begin
      failures++; $display("FAIL one_span: got %0d expected 4", last_acc - first_v + 1);
    end
  endtask

  task automatic test_handshake();
    run_pkt(PID_ACK, 11'd7, 1'b1, 0, 1'b0);
    checks++;
    if (ngot !== 1 || got[0] !== PID_ACK) begin
      failures++; $display("FAIL hs_bytes: got n=%0d b0=%h expected n=1 b0=d2", ngot, got[0]);
    end
    checks++;
    if (done_cyc !== 1) begin failures++; $display("FAIL hs_done: at %0d expected 1", done_cyc); end
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL hs_busy: got %b expected 0", busy); end
  endtask

  task automatic test_backpressure();
    byte unsigned pay[$];
    logic [15:0] crc;
    logic [7:0] exp_b [7];
    pay = '{8'h01, 8'h02, 8'h03, 8'h04};
    crc = crc_tx(pay);
    exp_b = '{PID_DATA1, 8'h01, 8'h02, 8'h03, 8'h04, crc[7:0], crc[15:8]};
    pops = 0;
    foreach (pay[k]) fq.push_back(pay[k]);
    run_pkt(PID_DATA1, 11'd4, 1'b0, 1, 1'b0);
    checks++;
    if (ngot !== 7) begin failures++; $display("FAIL bp_count: got %0d expected 7", ngot); end
    for (int i = 0; i < 7; i++) begin
      checks++;
      if (got[i] !== exp_b[i]) begin
        failures++; $display("FAIL bp_byte%0d: got %h expected %h", i, got[i], exp_b[i]);
      end
    end
    checks++;
    if (hold_err !== 0) begin failures++; $display("FAIL bp_hold: got %0d changes expected 0", hold_err); end
    checks++;
    if (pops !== 4) begin failures++; $display("FAIL bp_pops: got %0d expected 4", pops); end
  endtask

  task automatic test_underrun();
    pops = 0;
    fq.push_back(8'hAA); fq.push_back(8'hBB);
    run_pkt(PID_DATA0, 11'd3, 1'b0, 0, 1'b0);
    checks++;
    if (ngot !== 3 || got[1] !== 8'hAA || got[2] !== 8'hBB) begin
      failures++; $display("FAIL ur_bytes: got n=%0d %h %h expected n=3 aa bb", ngot, got[1], got[2]);
    end
    checks++;
    if (pops !== 2) begin failures++; $display("FAIL ur_pops: got %0d expected 2", pops); end
    checks++;
    if (done_cyc !== last_acc + 2) begin
      failures++; $display("FAIL ur_done_timing: done at %0d expected %0d", done_cyc, last_acc + 2);
    end
    checks++;
    if ({saw_under, saw_flush} !== 2'b11) begin
      failures++; $display("FAIL ur_pulses: underrun=%b flush=%b expected 1 1", saw_under, saw_flush);
    end
    @(negedge clk); #1;
    checks++;
    if ({underrun, fifo_flush, done} !== 3'b000) begin
      failures++; $display("FAIL ur_one_cycle: und=%b flush=%b done=%b expected 0 0 0", underrun, fifo_flush, done);
    end
  endtask

  task automatic test_busy_start();
    bit stray;
    run_pkt(PID_DATA0, 11'd0, 1'b0, 2, 1'b1);
    checks++;
    if (ngot !== 3 || got[0] !== PID_DATA0) begin
      failures++; $display("FAIL bs_bytes: got n=%0d b0=%h expected n=3 b0=c3", ngot, got[0]);
    end
    stray = 0;
    repeat (3) begin
      @(negedge clk); #1;
      if (txvalid || busy) stray = 1;
    end
    checks++;
    if (stray !== 1'b0) begin failures++; $display("FAIL bs_queued: got activity=%b expected 0", stray); end
  endtask

  task automatic test_back_to_back();
    run_pkt(PID_ACK, 11'd0, 1'b1, 0, 1'b0);
    pid = PID_DATA1; pid_only = 1'b1; start = 1'b1;
    @(negedge clk); start = 1'b0; #1;
    checks++;
    if (txvalid !== 1'b1 || utmi_data !== PID_DATA1) begin
      failures++; $display("FAIL b2b_pid: valid=%b data=%h expected 1 4b", txvalid, utmi_data);
    end
    @(negedge clk); #1;
    checks++;
    if (done !== 1'b1) begin failures++; $display("FAIL b2b_done: got %b expected 1", done); end
  endtask

  task automatic test_reset_mid();
    bit bad;
    fq.push_back(8'h11); fq.push_back(8'h22); fq.push_back(8'h33); fq.push_back(8'h44);
    @(negedge clk); pid = PID_DATA0; len = 11'd4; pid_only = 1'b0; start = 1'b1; txready = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk); @(negedge clk); #1;
    checks++;
    if (txvalid !== 1'b1 || utmi_data !== 8'h22) begin
      failures++; $display("FAIL rm_in_data: valid=%b data=%h expected 1 22", txvalid, utmi_data);
    end
    rst = 1'b1;
    @(negedge clk); #1;
    checks++;
    if ({txvalid, utmi_data, busy, done, underrun, fifo_flush, fifo_pop} !== 14'h0) begin
      failures++;
      $display("FAIL rm_outputs: valid=%b data=%h busy=%b done=%b und=%b flush=%b pop=%b expected all 0",
               txvalid, utmi_data, busy, done, underrun, fifo_flush, fifo_pop);
    end
    rst = 1'b0; txready = 1'b0; fq.delete();
    bad = 0;
    repeat (2) begin
      @(negedge clk); #1;
      if (done || fifo_flush || busy) bad = 1;
    end
    checks++;
    if (bad !== 1'b0) begin failures++; $display("FAIL rm_after: got activity=%b expected 0", bad); end
  endtask

  initial begin
    test_reset();
    test_zero_len();
    test_one_byte();
    test_handshake();
    test_backpressure();
    test_underrun();
    test_busy_start();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
